// File: rtl/router_wormhole.sv
// rtl/router_wormhole.sv - 5-port XY-routed wormhole mesh router with per-output packet locking.
// Define ROUTER_PERF_CNT_EN to add o_flit_cnt, a saturating 16-bit flit counter per output.
module router_wormhole #(
    parameter int X_LOC  = 0,
    parameter int Y_LOC  = 0,
    parameter int X_W    = 4,
    parameter int Y_W    = 4,
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5*FLIT_W-1:0] i_data,
    input  logic [4:0]          i_data_val,
    output logic [4:0]          o_en,
    output logic [5*FLIT_W-1:0] o_data,
    output logic [4:0]          o_data_val,
    input  logic [4:0]          i_en
`ifdef ROUTER_PERF_CNT_EN
    ,
    output logic [5*16-1:0]     o_flit_cnt
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [X_W-1:0] X_HERE   = X_W'(X_LOC);
    localparam logic [Y_W-1:0] Y_HERE   = Y_W'(Y_LOC);

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_EAST  = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_WEST  = 3'd4;

    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    logic [FLIT_W-1:0] r_mem  [5][DEPTH];
    logic [AW-1:0]     r_wptr [5];
    logic [AW-1:0]     r_rptr [5];
    logic [CW-1:0]     r_cnt  [5];

    logic [4:0]        r_lock_vld;
    logic [2:0]        r_lock_src [5];
    logic [2:0]        r_rr_ptr   [5];

    logic [FLIT_W-1:0] w_head  [5];
    logic [X_W-1:0]    w_xdest [5];
    logic [Y_W-1:0]    w_ydest [5];
    logic [2:0]        w_route [5];
    logic [4:0]        w_nonempty;
    logic [4:0]        w_is_head;
    logic [4:0]        w_is_tail;
    logic [4:0]        w_owns;
    logic [4:0]        w_push;
    logic [4:0]        w_pop;
    logic [4:0]        w_xfer;
    logic [2:0]        w_src   [5];
    logic [3:0]        w_sum;
    logic [2:0]        w_idx;

    always_comb begin : head_decode
        for (int p = 0; p < 5; p++) begin
            o_en[p]       = (r_cnt[p] != FULL_CNT);
            w_push[p]     = i_data_val[p] & o_en[p];
            w_head[p]     = r_mem[p][r_rptr[p]];
            w_nonempty[p] = (r_cnt[p] != '0);
            w_is_head[p]  = w_nonempty[p] & w_head[p][FLIT_W-1];
            w_is_tail[p]  = w_head[p][FLIT_W-2];
            w_xdest[p]    = w_head[p][FLIT_W-3 -: X_W];
            w_ydest[p]    = w_head[p][FLIT_W-3-X_W -: Y_W];
            if (w_xdest[p] > X_HERE) begin
                w_route[p] = P_EAST;
            end else if (w_xdest[p] < X_HERE) begin
                w_route[p] = P_WEST;
            end else if (w_ydest[p] > Y_HERE) begin
                w_route[p] = P_NORTH;
            end else if (w_ydest[p] < Y_HERE) begin
                w_route[p] = P_SOUTH;
            end else begin
                w_route[p] = P_LOCAL;
            end
        end
    end

    // An input that owns a lock is mid-packet; its head may not open a second packet elsewhere.
    always_comb begin : lock_owner
        w_owns = '0;
        for (int o = 0; o < 5; o++) begin
            for (int p = 0; p < 5; p++) begin
                if (r_lock_vld[o] == LOCKED && r_lock_src[o] == 3'(p)) begin
                    w_owns[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin : arbitrate
        w_xfer = '0;
        w_pop  = '0;
        w_sum  = '0;
        w_idx  = '0;
        for (int o = 0; o < 5; o++) begin
            w_src[o] = r_lock_src[o];
            if (r_lock_vld[o] == LOCKED) begin
                w_xfer[o] = i_en[o] & w_nonempty[r_lock_src[o]];
            end else if (i_en[o]) begin
                for (int k = 0; k < 5; k++) begin
                    w_sum = {1'b0, r_rr_ptr[o]} + 4'(k);
                    w_idx = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
                    if (!w_xfer[o] && w_is_head[w_idx] && !w_owns[w_idx] &&
                        w_route[w_idx] == 3'(o)) begin
                        w_xfer[o] = 1'b1;
                        w_src[o]  = w_idx;
                    end
                end
            end
            if (w_xfer[o]) begin
                w_pop[w_src[o]] = 1'b1;
            end
        end
    end

    always_comb begin : out_mux
        o_data     = '0;
        o_data_val = w_xfer;
        for (int o = 0; o < 5; o++) begin
            if (w_xfer[o]) begin
                o_data[o*FLIT_W +: FLIT_W] = w_head[w_src[o]];
            end
        end
    end

    // Storage has no reset: the pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 5; p++) begin
            if (w_push[p]) begin
                r_mem[p][r_wptr[p]] <= i_data[p*FLIT_W +: FLIT_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 5; p++) begin
                r_wptr[p] <= '0;
                r_rptr[p] <= '0;
                r_cnt[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (w_push[p]) begin
                    r_wptr[p] <= r_wptr[p] + 1'b1;
                end
                if (w_pop[p]) begin
                    r_rptr[p] <= r_rptr[p] + 1'b1;
                end
                if (w_push[p] && !w_pop[p]) begin
                    r_cnt[p] <= r_cnt[p] + 1'b1;
                end else if (w_pop[p] && !w_push[p]) begin
                    r_cnt[p] <= r_cnt[p] - 1'b1;
                end
            end
        end
    end

    // Priority rotates only on packet completion, so a locked packet never loses its turn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_vld <= '0;
            for (int o = 0; o < 5; o++) begin
                r_lock_src[o] <= '0;
                r_rr_ptr[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (w_xfer[o]) begin
                    if (w_is_tail[w_src[o]]) begin
                        r_lock_vld[o] <= UNLOCKED;
                        r_rr_ptr[o]   <= (w_src[o] == 3'd4) ? 3'd0 : w_src[o] + 3'd1;
                    end else if (r_lock_vld[o] == UNLOCKED) begin
                        r_lock_vld[o] <= LOCKED;
                        r_lock_src[o] <= w_src[o];
                    end
                end
            end
        end
    end

`ifdef ROUTER_PERF_CNT_EN
    logic [15:0] r_flit_cnt [5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < 5; o++) begin
                r_flit_cnt[o] <= '0;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (w_xfer[o] && r_flit_cnt[o] != 16'hFFFF) begin
                    r_flit_cnt[o] <= r_flit_cnt[o] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        o_flit_cnt = '0;
        for (int o = 0; o < 5; o++) begin
            o_flit_cnt[o*16 +: 16] = r_flit_cnt[o];
        end
    end
`endif

endmodule

// File: tb/tb_router_wormhole.sv
// tb/tb_router_wormhole.sv - directed scoreboard bench for router_wormhole at tile (1,1).
module tb_router_wormhole;
    localparam int FW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [5*FW-1:0] i_data;
    logic [4:0]      i_data_val;
    logic [4:0]      o_en;
    logic [5*FW-1:0] o_data;
    logic [4:0]      o_data_val;
    logic [4:0]      i_en;
`ifdef ROUTER_PERF_CNT_EN
    logic [79:0]     o_flit_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] sb [5][$];
    bit mon_en = 1'b0;

    logic [FW-1:0] f;
    logic [FW-1:0] wf;
    logic [FW-1:0] nf [4];
    int west_cyc;
    int nloc;
    int rr_log [$];
    int rr_exp [6];

    always #5 clk = ~clk;

    router_wormhole #(
        .X_LOC(1), .Y_LOC(1), .X_W(4), .Y_W(4), .FLIT_W(FW), .DEPTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_data     (i_data),
        .i_data_val (i_data_val),
        .o_en       (o_en),
        .o_data     (o_data),
        .o_data_val (o_data_val),
        .i_en       (i_en)
`ifdef ROUTER_PERF_CNT_EN
        ,
        .o_flit_cnt (o_flit_cnt)
`endif
    );

    function automatic logic [FW-1:0] mk(bit h, bit t, int x, int y, int pl);
        return {h, t, 4'(x), 4'(y), 22'(pl)};
    endfunction

    task automatic chk(string tag, logic [159:0] got, logic [159:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        i_data     = '0;
        i_data_val = '0;
    endtask

    task automatic put(int p, logic [FW-1:0] fl);
        i_data[p*FW +: FW] = fl;
        i_data_val[p]      = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("val_gated_by_ien", 160'(o_data_val & ~i_en), 160'd0);
            if (mon_en) begin
                for (int o = 0; o < 5; o++) begin
                    if (o_data_val[o]) begin
                        checks++;
                        assert (sb[o].size() != 0) else begin
                            errors++;
                            $error("FAIL sb_unexpected out=%0d got=%0h exp=none", o, o_data[o*FW +: FW]);
                        end
                        if (sb[o].size() != 0) begin
                            chk("sb_flit", 160'(o_data[o*FW +: FW]), 160'(sb[o].pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        clr();
        i_en   = 5'h1f;
        rr_exp = '{1, 2, 3, 1, 2, 3};
        #2;
        chk("rst_o_en", 160'(o_en), 160'h1f);
        chk("rst_val", 160'(o_data_val), 160'd0);
        chk("rst_data", 160'(o_data), 160'd0);
        step();
        step();
        reset  = 1'b0;
        mon_en = 1'b1;

        // single head+tail flit local -> (2,1) leaves east one cycle after accept
        f = mk(1, 1, 2, 1, 'h11);
        put(0, f);
        sb[2].push_back(f);
        @(negedge clk);
        chk("t1_no_bypass", 160'(o_data_val), 160'd0);
        step();
        clr();
        @(negedge clk);
        chk("t1_val", 160'(o_data_val), 160'b00100);
        chk("t1_data", 160'(o_data[2*FW +: FW]), 160'(f));
        step();
        @(negedge clk);
        chk("t1_idle", 160'(o_data_val), 160'd0);
        step();

        // wormhole lock: 4-flit north packet holds local against a west single flit
        nf[0] = mk(1, 0, 1, 1, 'h100);
        nf[1] = mk(0, 0, 0, 0, 'h101);
        nf[2] = mk(0, 0, 0, 0, 'h102);
        nf[3] = mk(0, 1, 0, 0, 'h103);
        wf    = mk(1, 1, 1, 1, 'h4444);
        for (int i = 0; i < 4; i++) sb[0].push_back(nf[i]);
        sb[0].push_back(wf);
        west_cyc = -1;
        nloc     = 0;
        for (int c = 0; c < 8; c++) begin
            clr();
            if (c < 4) put(1, nf[c]);
            if (c == 1) put(4, wf);
            @(negedge clk);
            if (o_data_val[0]) begin
                nloc++;
                if (o_data[0 +: FW] === wf) west_cyc = c;
            end
            step();
        end
        clr();
        chk("wh_west_cycle", 160'(west_cyc), 160'd5);
        chk("wh_local_count", 160'(nloc), 160'd5);

        // round robin: inputs 1,2,3 each queue two single flits to east
        for (int k = 0; k < 2; k++)
            for (int p = 1; p < 4; p++)
                sb[2].push_back(mk(1, 1, 2, 0, p*16 + k));
        for (int c = 0; c < 10; c++) begin
            clr();
            if (c < 2)
                for (int p = 1; p < 4; p++) put(p, mk(1, 1, 2, 0, p*16 + c));
            @(negedge clk);
            if (o_data_val[2]) rr_log.push_back(int'(o_data[2*FW+4 +: 4]));
            step();
        end
        clr();
        chk("rr_count", 160'(rr_log.size()), 160'd6);
        for (int i = 0; i < 6; i++)
            chk("rr_order", 160'((i < rr_log.size()) ? rr_log[i] : -1), 160'(rr_exp[i]));

        // backpressure: local blocked, south offers six flits, only four fit
        i_en = 5'b11110;
        for (int k = 0; k < 6; k++) begin
            clr();
            f = mk(1, 1, 1, 1, 'h300 + k);
            put(3, f);
            if (k < 4) sb[0].push_back(f);
            @(negedge clk);
            chk("bp_o_en", 160'(o_en[3]), 160'(k < 4));
            chk("bp_stall", 160'(o_data_val[0]), 160'd0);
            step();
        end
        clr();
        @(negedge clk);
        chk("bp_full_hold", 160'(o_en[3]), 160'd0);
        step();
        i_en = 5'h1f;
        @(negedge clk);
        chk("bp_drain_val", 160'(o_data_val[0]), 160'd1);
        chk("bp_en_still_low", 160'(o_en[3]), 160'd0);
        step();
        @(negedge clk);
        chk("bp_en_back", 160'(o_en[3]), 160'd1);
        for (int i = 0; i < 5; i++) step();

        // reset mid-packet with east locked and a stalled flit in the north FIFO
        i_en = 5'b11110;
        clr();
        f = mk(1, 0, 2, 1, 'h500);
        put(0, f);
        sb[2].push_back(f);
        step();
        clr();
        f = mk(0, 0, 0, 0, 'h501);
        put(0, f);
        sb[2].push_back(f);
        put(1, mk(1, 1, 1, 1, 'h5ff));
        step();
        clr();
        put(0, mk(0, 0, 0, 0, 'h502));
        step();
        clr();
        chk("rst_pre_val", 160'(o_data_val[2]), 160'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_val", 160'(o_data_val), 160'd0);
        chk("rst_mid_en", 160'(o_en), 160'h1f);
        chk("rst_mid_data", 160'(o_data), 160'd0);
        for (int o = 0; o < 5; o++) sb[o].delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        i_en  = 5'h1f;
        f = mk(1, 1, 2, 1, 'h600);
        put(1, f);
        sb[2].push_back(f);
        @(negedge clk);
        chk("rst_no_stale", 160'(o_data_val), 160'd0);
        step();
        clr();
        @(negedge clk);
        chk("rst_new_route", 160'(o_data_val), 160'b00100);
        chk("rst_new_data", 160'(o_data[2*FW +: FW]), 160'(f));
        step();
        step();

`ifdef ROUTER_PERF_CNT_EN
        for (int c = 0; c < 3; c++) begin
            clr();
            f = mk(1, 1, 1, 2, 'h700 + c);
            put(0, f);
            sb[1].push_back(f);
            step();
        end
        clr();
        step();
        step();
        @(negedge clk);
        chk("perf_cnt3", 160'(o_flit_cnt[16 +: 16]), 160'd3);
        step();
        mon_en = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            put(0, mk(1, 1, 1, 2, i));
            step();
        end
        clr();
        step();
        step();
        step();
        @(negedge clk);
        chk("perf_cnt_sat", 160'(o_flit_cnt[16 +: 16]), 160'hFFFF);
        step();
        mon_en = 1'b1;
`endif

        for (int o = 0; o < 5; o++) chk("sb_drained", 160'(sb[o].size()), 160'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
